// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encoding and reset vector shared by the fetch sequencer, PC register and benches.
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    KILL  = 2'd3
  } state_e;
  localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one-outstanding instruction fetch controller driving the PC register,
// instruction memory and a valid/ready handshake to decode, with redirect and halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_wen_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i
);
  state_e            state_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [31:0]       instr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      instr_pc_q   <= '0;
      instr_q      <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (!redirect_i && !halt_i) begin
            fetch_addr_q <= pc_i;
            state_q      <= FETCH;
          end
        FETCH:
          if (redirect_i) state_q <= imem_ack_i ? IDLE : KILL;
          else if (imem_ack_i) begin
            instr_q    <= imem_rdata_i;
            instr_pc_q <= fetch_addr_q;
            state_q    <= VALID;
          end
        VALID:
          if (redirect_i) state_q <= IDLE;
          else if (instr_ready_i && !halt_i) begin
            fetch_addr_q <= pc_i;
            state_q      <= FETCH;
          end else if (instr_ready_i) state_q <= IDLE;
        KILL:
          if (imem_ack_i) state_q <= IDLE;
      endcase
    end
  end
  // A redirect always wins the PC write; otherwise only a completed fetch advances it.
  always_comb begin
    pc_wen_o   = redirect_i || (state_q == FETCH && imem_ack_i);
    pc_next_o  = redirect_i ? {redirect_pc_i[ADDR_W-1:2], 2'b00} : fetch_addr_q + ADDR_W'(PC_STEP);
    imem_req_o = state_q == FETCH || state_q == KILL;
  end
  assign imem_addr_o   = fetch_addr_q;
  assign instr_valid_o = state_q == VALID;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with queued expectations checked by a negedge monitor.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] pc;
  logic        pc_wen;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic        instr_valid;
  logic        instr_ready = 0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 0;
  logic [31:0] redirect_pc = 0;
  logic        halt = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pcw_q[$];
  logic [63:0] exp_instr_q[$];
  logic        prev_req = 0;
  logic [31:0] prev_addr = 0;

  fetch_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .pc_wen_o(pc_wen), .pc_next_o(pc_next),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .halt_i(halt)
  );

  always #5 clk = ~clk;

  // External PC register that the sequencer controls.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_VECTOR;
    else if (pc_wen) pc <= pc_next;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic unexpected(string name, logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h required no event", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch_ack(int waits, logic [31:0] data);
    wait_req();
    repeat (waits) step();
    imem_ack = 1;
    imem_rdata = data;
    step();
    imem_ack = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) unexpected("req_addr", imem_addr);
        else chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (imem_req && prev_req) chk("addr_stable", imem_addr, prev_addr);
      if (pc_wen) begin
        if (exp_pcw_q.size() == 0) unexpected("pc_wen", pc_next);
        else chk("pc_next", pc_next, exp_pcw_q.pop_front());
      end
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) unexpected("instr_valid", instr);
        else if (instr_ready && !redirect) begin
          logic [63:0] e;
          e = exp_instr_q.pop_front();
          chk("instr", instr, e[63:32]);
          chk("instr_pc", instr_pc, e[31:0]);
        end
      end
    end
    prev_req = imem_req && rst_n;
    prev_addr = imem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    halt = 0;
    repeat (2) step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_wen", {31'd0, pc_wen}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    // 1: first fetch from the reset vector
    exp_addr_q.push_back(32'h0040_0000);
    exp_pcw_q.push_back(32'h0040_0004);
    exp_instr_q.push_back({32'h2008_0005, 32'h0040_0000});
    rst_n = 1;
    fetch_ack(2, 32'h2008_0005);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h2008_0005);
    chk("t1_instr_pc", instr_pc, 32'h0040_0000);
    // 2: decode stalls, then accepts
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_instr_hold", instr, 32'h2008_0005);
      chk("t2_pc_hold", instr_pc, 32'h0040_0000);
      chk("t2_no_req", {31'd0, imem_req}, 32'd0);
      chk("t2_no_pcw", {31'd0, pc_wen}, 32'd0);
    end
    exp_addr_q.push_back(32'h0040_0004);
    instr_ready = 1;
    step();
    instr_ready = 0;
    chk("t2_next_addr", imem_addr, 32'h0040_0004);
    // 3: redirect during an outstanding fetch
    step();
    exp_pcw_q.push_back(32'h0040_0100);
    redirect = 1;
    redirect_pc = 32'h0040_0103;
    step();
    redirect = 0;
    chk("t3_kill_req", {31'd0, imem_req}, 32'd1);
    chk("t3_kill_addr", imem_addr, 32'h0040_0004);
    chk("t3_pc", pc, 32'h0040_0100);
    step();
    exp_addr_q.push_back(32'h0040_0100);
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 0;
    chk("t3_dropped", {31'd0, instr_valid}, 32'd0);
    chk("t3_idle", {31'd0, imem_req}, 32'd0);
    step();
    chk("t3_new_addr", imem_addr, 32'h0040_0100);
    // 4: redirect coinciding with ack
    exp_pcw_q.push_back(32'h0040_0200);
    exp_addr_q.push_back(32'h0040_0200);
    imem_ack = 1;
    imem_rdata = 32'hBAD0_BAD0;
    redirect = 1;
    redirect_pc = 32'h0040_0201;
    step();
    imem_ack = 0;
    redirect = 0;
    chk("t4_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_idle", {31'd0, imem_req}, 32'd0);
    step();
    chk("t4_fetch", {31'd0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h0040_0200);
    // 5: halt while holding an instruction
    exp_pcw_q.push_back(32'h0040_0204);
    exp_instr_q.push_back({32'h1111_1111, 32'h0040_0200});
    fetch_ack(1, 32'h1111_1111);
    halt = 1;
    instr_ready = 1;
    step();
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_halt_no_req", {31'd0, imem_req}, 32'd0);
    end
    exp_addr_q.push_back(32'h0040_0204);
    halt = 0;
    step();
    chk("t5_resume_addr", imem_addr, 32'h0040_0204);
    // 5b: sequential advance wraps at the top of the address space
    exp_pcw_q.push_back(32'hFFFF_FFFC);
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    imem_ack = 1;
    step();
    imem_ack = 0;
    step();
    exp_pcw_q.push_back(32'h0000_0000);
    exp_instr_q.push_back({32'h2222_2222, 32'hFFFF_FFFC});
    fetch_ack(0, 32'h2222_2222);
    chk("t5_wrap_pc", pc, 32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0000);
    instr_ready = 1;
    step();
    instr_ready = 0;
    // 6: asynchronous reset mid-fetch, then a stray ack
    step();
    #2;
    rst_n = 0;
    halt = 1;
    #1;
    chk("t6_req", {31'd0, imem_req}, 32'd0);
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_addr", imem_addr, 32'd0);
    chk("t6_instr_pc", instr_pc, 32'd0);
    repeat (2) step();
    rst_n = 1;
    imem_ack = 1;
    step();
    imem_ack = 0;
    chk("t6_stray_ignored", {31'd0, imem_req}, 32'd0);
    chk("t6_stray_no_valid", {31'd0, instr_valid}, 32'd0);
    exp_addr_q.push_back(32'h0040_0000);
    halt = 0;
    step();
    chk("t6_fresh_addr", imem_addr, 32'h0040_0000);
    exp_pcw_q.push_back(32'h0040_0004);
    exp_instr_q.push_back({32'h3333_3333, 32'h0040_0000});
    fetch_ack(2, 32'h3333_3333);
    exp_addr_q.push_back(32'h0040_0004);
    instr_ready = 1;
    step();
    instr_ready = 0;
    step();
    @(negedge clk);
    chk("left_addr", exp_addr_q.size(), 32'd0);
    chk("left_pcw", exp_pcw_q.size(), 32'd0);
    chk("left_instr", exp_instr_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the PC register.
- Owns the PC register's write-enable and next-value inputs.
- Issues one instruction-memory request at a time and presents the fetched instruction to decode through a valid/ready handshake.
- Handles control-flow redirects and halt; sits between the PC register, instruction memory and the decode stage.

Parameters:
- PC_STEP, 4, byte increment added to the fetch address on sequential advance.
- ADDR_W, 32, width of the PC and memory address.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pc  in  ADDR_W  current PC register value.
- pc_wen  out  1  PC register write enable.
- pc_next  out  ADDR_W  value written to the PC register when pc_wen=1.
- imem_req  out  1  instruction-memory request, held until ack.
- imem_addr  out  ADDR_W  request address; stable while imem_req=1.
- imem_ack  in  1  memory completion; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr_ready  in  1  decode accepts the instruction when valid&ready.
- instr  out  32  registered instruction word.
- instr_pc  out  ADDR_W  address instr was fetched from.
- redirect  in  1  branch/jump/exception redirect request.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  level; blocks issue of new fetches.

Behaviour:
- States are IDLE, FETCH, VALID, KILL.
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - imem_req, pc_wen, instr_valid = 0.
  - instr, instr_pc, imem_addr (fetch_addr register) = 0.
  - Reset asserted mid-fetch abandons the outstanding request immediately; a late ack after release in IDLE is ignored.
- pc_wen and pc_next are combinational from state and inputs; pc_wen is a single-cycle pulse per event.
- IDLE:
  - imem_req=0.
  - If halt=0: fetch_addr<=pc, go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=fetch_addr.
  - On imem_ack with redirect=0:
    - instr<=imem_rdata, instr_pc<=fetch_addr.
    - pc_wen=1, pc_next=fetch_addr+PC_STEP (mod 2^ADDR_W; wraps without error).
    - Go to VALID.
  - Without ack: remain in FETCH.
- VALID:
  - instr_valid=1; instr and instr_pc are stable until the handshake.
  - On instr_ready=1:
    - If halt=0: fetch_addr<=pc, go to FETCH (back-to-back issue, no bubble).
    - If halt=1: go to IDLE.
  - Without ready: hold; imem_req=0.
- KILL:
  - imem_req=1 with the old fetch_addr until imem_ack; imem_rdata is discarded.
  - Then go to IDLE.
- redirect (highest priority, any state):
  - pc_wen=1, pc_next={redirect_pc[ADDR_W-1:2],2'b00} (forced word alignment).
  - FETCH and no ack that cycle: go to KILL.
  - FETCH with ack the same cycle: discard the data, no sequential pc_wen, go to IDLE.
  - VALID: instr_valid drops the next cycle even if instr_ready=1 that cycle; the instruction is not counted as accepted. Go to IDLE.
  - IDLE: stay IDLE; the new pc is sampled the following cycle.
  - KILL: update the PC again and stay in KILL.
- Redirect latency: redirect at cycle t means imem_req carries the new address no earlier than t+2 (t+2 if memory is idle).
- halt:
  - Never aborts an outstanding request or a held instruction.
  - Only gates the IDLE→FETCH and VALID→FETCH transitions.
- Invariants:
  - At most one outstanding request.
  - imem_addr never changes while imem_req=1.
  - Exactly one pc_wen per completed non-redirected fetch.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, VALID=2'd2, KILL=2'd3)
  - the reset vector constant 32'h00400000, used by the PC register and benches.
- No sub-module; a single always block for state and registers plus one combinational block for pc_wen/pc_next/imem_req.

Test Plan:
1. Release reset with pc=0x00400000, halt=0; ack 2 cycles after req with rdata=0x20080005.
   -> imem_addr=0x00400000; pc_wen pulse with pc_next=0x00400004 in the ack cycle; next cycle instr_valid=1, instr=0x20080005, instr_pc=0x00400000.
2. Hold instr_ready=0 for 3 cycles in VALID.
   -> instr and instr_pc are stable, imem_req=0, no pc_wen. Ready=1 gives req for 0x00400004 the next cycle.
3. Redirect to 0x00400103 two cycles into an outstanding fetch at 0x00400004.
   -> pc_wen with pc_next=0x00400100; req stays at 0x00400004 until ack; data is dropped (instr_valid stays 0); the next req is 0x00400100.
4. Redirect and imem_ack in the same FETCH cycle.
   -> only the redirect pc_wen occurs; no instr_valid; IDLE, then FETCH at the redirect target.
5. halt=1 while in VALID, then ready=1.
   -> goes to IDLE, no imem_req while halt=1; deassert halt -> FETCH at the current pc. Separately, fetch_addr=0xFFFFFFFC with ack -> pc_next=0x00000000.
6. Assert reset mid-fetch, release 2 cycles later, then pulse imem_ack once.
   -> all outputs 0 asynchronously; the stray ack is ignored; a fresh fetch begins from IDLE.
